// File: rtl/cdc_handshake_ctrl_if.sv
//==============================================================================
// Module      : cdc_handshake_ctrl_if
// Description : Handshake/data bundle between a toggle-request source and the
//               destination-domain capture controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cdc_handshake_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic              sync_req;
    logic [DATA_W-1:0] data_in;
    logic              dst_ready;
    logic              clear_err;
    logic              ack_toggle;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  xfer_count;
    logic              overrun_err;
    logic              timeout_err;

    modport slave (
        input  enable, sync_req, data_in, dst_ready, clear_err,
        output ack_toggle, data_valid, data_out, xfer_count, overrun_err, timeout_err
    );

    modport master (
        output enable, sync_req, data_in, dst_ready, clear_err,
        input  ack_toggle, data_valid, data_out, xfer_count, overrun_err, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/cdc_handshake_ctrl.sv
//==============================================================================
// Module      : cdc_handshake_ctrl
// Description : Destination-side toggle handshake: captures data on a request
//               edge, presents it until consumed or timed out, returns an ack.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cdc_handshake_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic              Bclk,
    input  wire logic              reset,
    cdc_handshake_ctrl_if.slave    bus
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_VALID   = 2'd2
    } state_t;

    state_t              state_q;
    logic                req_seen_q;
    logic                ack_toggle_q;
    logic                data_valid_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [CNT_W-1:0]    xfer_count_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                overrun_err_q;
    logic                timeout_err_q;

    logic                w_edge;
    logic                w_timeout;
    logic [CNT_W-1:0]    xfer_count_d;
    logic [WAIT_W-1:0]   wait_d;

    assign w_edge       = (bus.sync_req != req_seen_q);
    assign w_timeout    = (TIMEOUT != 0) && (wait_q == C_TIMEOUT) && !bus.dst_ready;
    assign xfer_count_d = xfer_count_q + 1'b1;
    assign wait_d       = wait_q + 1'b1;

    always_ff @(posedge Bclk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_seen_q    <= 1'b0;
            ack_toggle_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            data_out_q    <= '0;
            xfer_count_q  <= '0;
            wait_q        <= '0;
            overrun_err_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // Clear first so that any set below in the same cycle takes priority.
            if (bus.clear_err) begin
                overrun_err_q <= 1'b0;
                timeout_err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_edge && bus.enable) begin
                        state_q <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    data_out_q   <= bus.data_in;
                    req_seen_q   <= bus.sync_req;
                    wait_q       <= '0;
                    data_valid_q <= 1'b1;
                    state_q      <= S_VALID;
                end

                S_VALID: begin
                    // A new toggle here is left pending; it is serviced from IDLE.
                    if (w_edge) begin
                        overrun_err_q <= 1'b1;
                    end
                    if (bus.dst_ready) begin
                        ack_toggle_q <= ~ack_toggle_q;
                        xfer_count_q <= xfer_count_d;
                        data_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (w_timeout) begin
                        timeout_err_q <= 1'b1;
                        ack_toggle_q  <= ~ack_toggle_q;
                        data_valid_q  <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                default: begin
                    data_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_toggle  = ack_toggle_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.data_out    = data_out_q;
    assign bus.xfer_count  = xfer_count_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_ctrl.sv
//==============================================================================
// Module      : tb_cdc_handshake_ctrl
// Description : Directed and randomized checks of cdc_handshake_ctrl against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cdc_handshake_ctrl;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic Bclk = 1'b0;
    logic reset;
    always #5 Bclk = ~Bclk;

    cdc_handshake_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cdc_handshake_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Bclk (Bclk),
        .reset(reset),
        .bus  (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: age < 0 idle, age == 0 capture in progress,
    // age >= 1 word presented with (age-1) cycles already waited.
    int       m_age;
    bit       m_seen;
    bit       m_ack;
    bit [7:0] m_dout;
    int       m_count;
    bit       m_ov;
    bit       m_to;

    bit       req_lvl;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit rq, input bit [7:0] d,
                              input bit rdy, input bit clr);
        bit pend;
        bit set_ov;
        bit set_to;
        if (r) begin
            m_age = -1; m_seen = 0; m_ack = 0; m_dout = 0;
            m_count = 0; m_ov = 0; m_to = 0;
            return;
        end
        pend   = (rq != m_seen);
        set_ov = 0;
        set_to = 0;
        if (m_age < 0) begin
            if (pend && en) m_age = 0;
        end else if (m_age == 0) begin
            m_dout = d;
            m_seen = rq;
            m_age  = 1;
        end else begin
            if (pend) set_ov = 1;
            if (rdy) begin
                m_ack   = !m_ack;
                m_count = (m_count + 1) % (1 << CNT_W);
                m_age   = -1;
            end else if (TIMEOUT != 0 && (m_age - 1) == TIMEOUT) begin
                set_to = 1;
                m_ack  = !m_ack;
                m_age  = -1;
            end else begin
                m_age++;
            end
        end
        m_ov = set_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_to = set_to ? 1'b1 : (clr ? 1'b0 : m_to);
    endtask

    task automatic cyc(input bit r, input bit en, input bit rq, input bit [7:0] d,
                       input bit rdy, input bit clr);
        @(negedge Bclk);
        reset         = r;
        bus.enable    = en;
        bus.sync_req  = rq;
        bus.data_in   = d;
        bus.dst_ready = rdy;
        bus.clear_err = clr;
        model_step(r, en, rq, d, rdy, clr);
        @(posedge Bclk);
        #1;
        check_val("data_valid", 32'(bus.data_valid), 32'(m_age >= 1));
        check_val("data_out", 32'(bus.data_out), 32'(m_dout));
        check_val("ack_toggle", 32'(bus.ack_toggle), 32'(m_ack));
        check_val("xfer_count", 32'(bus.xfer_count), 32'(m_count));
        check_val("overrun_err", 32'(bus.overrun_err), 32'(m_ov));
        check_val("timeout_err", 32'(bus.timeout_err), 32'(m_to));
    endtask

    task automatic do_reset();
        cyc(1, 1, 0, 8'h00, 0, 0);
        cyc(1, 1, 0, 8'h00, 0, 0);
        req_lvl = 0;
    endtask

    initial begin
        bit ack0;
        int cnt0;
        reset = 1'b1;
        bus.enable = 0; bus.sync_req = 0; bus.data_in = 0;
        bus.dst_ready = 0; bus.clear_err = 0;
        m_age = -1; m_seen = 0; m_ack = 0; m_dout = 0;
        m_count = 0; m_ov = 0; m_to = 0; req_lvl = 0;

        // Reset state
        do_reset();
        check_val("rst_valid", 32'(bus.data_valid), 32'd0);
        check_val("rst_count", 32'(bus.xfer_count), 32'd0);
        check_val("rst_ack", 32'(bus.ack_toggle), 32'd0);

        // Basic transfer with a 3-cycle turnaround
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'hA5, 1, 0);
        cyc(0, 1, 1, 8'hA5, 1, 0);
        check_val("basic_not_yet", 32'(bus.data_valid), 32'd0);
        cyc(0, 1, 1, 8'hA5, 1, 0);
        check_val("basic_valid", 32'(bus.data_valid), 32'd1);
        check_val("basic_data", 32'(bus.data_out), 32'hA5);
        cyc(0, 1, 1, 8'hA5, 1, 0);
        check_val("basic_ack", 32'(bus.ack_toggle), 32'd1);
        check_val("basic_count", 32'(bus.xfer_count), 32'd1);
        check_val("basic_done", 32'(bus.data_valid), 32'd0);

        // Backpressure until timeout
        cyc(0, 1, 0, 8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 8'h3C, 0, 0);
            check_val("to_hold_valid", 32'(bus.data_valid), 32'd1);
        end
        cyc(0, 1, 0, 8'h3C, 0, 0);
        check_val("to_dropped", 32'(bus.data_valid), 32'd0);
        check_val("to_err", 32'(bus.timeout_err), 32'd1);
        check_val("to_ack", 32'(bus.ack_toggle), 32'd0);
        check_val("to_count", 32'(bus.xfer_count), 32'd1);
        cyc(0, 1, 0, 8'h3C, 0, 1);
        check_val("to_clear", 32'(bus.timeout_err), 32'd0);

        // Ready arriving exactly at the timeout boundary
        cyc(0, 1, 1, 8'h5A, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 8'h5A, 0, 0);
        cyc(0, 1, 1, 8'h5A, 1, 0);
        check_val("bnd_no_err", 32'(bus.timeout_err), 32'd0);
        check_val("bnd_count", 32'(bus.xfer_count), 32'd2);
        check_val("bnd_ack", 32'(bus.ack_toggle), 32'd1);

        // Overrun: second toggle while the first word is still presented
        ack0 = bus.ack_toggle;
        cyc(0, 1, 0, 8'h11, 0, 0);
        cyc(0, 1, 0, 8'h11, 0, 0);
        cyc(0, 1, 1, 8'h22, 0, 0);
        check_val("ovr_flag", 32'(bus.overrun_err), 32'd1);
        check_val("ovr_first_held", 32'(bus.data_out), 32'h11);
        cyc(0, 1, 1, 8'h22, 1, 0);
        cyc(0, 1, 1, 8'h22, 0, 0);
        cyc(0, 1, 1, 8'h22, 0, 0);
        check_val("ovr_second", 32'(bus.data_out), 32'h22);
        cyc(0, 1, 1, 8'h22, 1, 0);
        check_val("ovr_two_acks", 32'(bus.ack_toggle), 32'(ack0));
        cyc(0, 1, 1, 8'h22, 0, 1);
        check_val("ovr_clear", 32'(bus.overrun_err), 32'd0);

        // Enable gating holds a pending toggle
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 8'h77, 1, 0);
            check_val("gate_idle", 32'(bus.data_valid), 32'd0);
        end
        cyc(0, 1, 0, 8'h77, 1, 0);
        cyc(0, 1, 0, 8'h77, 0, 0);
        check_val("gate_capture", 32'(bus.data_valid), 32'd1);
        cyc(0, 0, 0, 8'h77, 1, 0);
        check_val("gate_no_abort", 32'(bus.data_valid), 32'd0);

        // Counter wrap after 16 completed transfers
        do_reset();
        for (int t = 0; t < 16; t++) begin
            req_lvl = !req_lvl;
            for (int i = 0; i < 3; i++) cyc(0, 1, req_lvl, 8'(t), 1, 0);
            if (t == 14) check_val("wrap_15m", 32'(bus.xfer_count), 32'd15);
        end
        check_val("wrap_zero", 32'(bus.xfer_count), 32'd0);

        // Reset during VALID abandons the word
        req_lvl = !req_lvl;
        cyc(0, 1, req_lvl, 8'hEE, 0, 0);
        cyc(0, 1, req_lvl, 8'hEE, 0, 0);
        cyc(0, 1, req_lvl, 8'hEE, 0, 0);
        cnt0 = 0;
        cyc(1, 1, req_lvl, 8'hEE, 1, 0);
        check_val("rstv_valid", 32'(bus.data_valid), 32'd0);
        check_val("rstv_data", 32'(bus.data_out), 32'd0);
        check_val("rstv_ack", 32'(bus.ack_toggle), 32'd0);
        check_val("rstv_count", 32'(bus.xfer_count), 32'(cnt0));
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit r;
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) req_lvl = !req_lvl;
            if (r) begin
                cyc(1, 1, req_lvl, 8'($urandom), 0, 0);
                req_lvl = 0;
            end else begin
                cyc(0, ($urandom_range(0, 7) != 0), req_lvl, 8'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
